// File: rtl/crp16_alu_seq.sv
// CRP16 registered ALU: single-cycle add/sub/logic/SLT and iterative 1-bit-per-cycle shifts.
// Result and NZVC flags are registered and change only on done or reset.
module crp16_alu_seq #(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned SW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       select,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic             v,
  output logic             c,
  output logic             n,
  output logic             z
);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] alu_q, alu_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [1:0]       shop_q, shop_d;
  logic             done_q, done_d;
  logic             v_q, v_d, c_q, c_d, n_q, n_d, z_q, z_d;

  logic [SW-1:0]    shamt;
  logic             is_shift;
  logic [WIDTH-1:0] y_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] op_res;
  logic             op_c, op_v;
  logic [WIDTH-1:0] step_res;
  logic             step_out;

  // Single-cycle datapath; shifts fall through to x here, which is the s=0 result.
  always_comb begin
    shamt    = y[SW-1:0];
    is_shift = (select[3:2] == 2'b11) && (select[1:0] != 2'b11);
    y_b      = select[0] ? ~y : y;
    sum      = {1'b0, x} + {1'b0, y_b} + {{WIDTH{1'b0}}, select[0]};
    op_res   = '0;
    op_c     = 1'b0;
    op_v     = 1'b0;
    if (!select[3]) begin
      op_res = sum[WIDTH-1:0];
      op_c   = sum[WIDTH];
      op_v   = (x[WIDTH-1] == y_b[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    end else if (!select[2]) begin
      unique case (select[1:0])
        2'b00: op_res = x & y;
        2'b01: op_res = x | y;
        2'b10: op_res = x ^ y;
        2'b11: op_res = ~x;
      endcase
    end else begin
      unique case (select[1:0])
        2'b11:   op_res = {{(WIDTH-1){1'b0}}, $signed(x) < $signed(y)};
        default: op_res = x;
      endcase
    end
  end

  // One shift step of the working register; step_out is the bit leaving it.
  always_comb begin
    unique case (shop_q)
      2'b00: begin
        step_res = {work_q[WIDTH-2:0], 1'b0};
        step_out = work_q[WIDTH-1];
      end
      2'b01: begin
        step_res = {1'b0, work_q[WIDTH-1:1]};
        step_out = work_q[0];
      end
      default: begin
        step_res = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        step_out = work_q[0];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    shop_d  = shop_q;
    alu_d   = alu_q;
    v_d     = v_q;
    c_d     = c_q;
    n_d     = n_q;
    z_d     = z_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_shift && (shamt != '0)) begin
            state_d = StShift;
            work_d  = x;
            cnt_d   = shamt;
            shop_d  = select[1:0];
          end else begin
            alu_d  = op_res;
            v_d    = op_v;
            c_d    = op_c;
            n_d    = op_res[WIDTH-1];
            z_d    = (op_res == '0);
            done_d = 1'b1;
          end
        end
      end
      StShift: begin
        work_d = step_res;
        cnt_d  = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          state_d = StIdle;
          alu_d   = step_res;
          v_d     = 1'b0;
          c_d     = step_out;
          n_d     = step_res[WIDTH-1];
          z_d     = (step_res == '0);
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= '0;
      shop_q  <= '0;
      alu_q   <= '0;
      v_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      shop_q  <= shop_d;
      alu_q   <= alu_d;
      v_q     <= v_d;
      c_q     <= c_d;
      n_q     <= n_d;
      z_q     <= z_d;
      done_q  <= done_d;
    end
  end

  assign ready   = (state_q == StIdle);
  assign done    = done_q;
  assign alu_out = alu_q;
  assign v       = v_q;
  assign c       = c_q;
  assign n       = n_q;
  assign z       = z_q;

endmodule

// File: tb/tb_crp16_alu_seq.sv
// Bench for crp16_alu_seq: a 16-bit and an 8-bit instance checked against an arithmetic model.
module tb_crp16_alu_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start16 = 1'b0;
  logic        start8 = 1'b0;
  logic [63:0] bx = '0;
  logic [63:0] by = '0;
  logic [3:0]  bsel = '0;

  logic        ready16, done16, v16, c16, n16, z16;
  logic [15:0] out16;
  logic        ready8, done8, v8, c8, n8, z8;
  logic [7:0]  out8;

  int          cur_w = 16;
  logic [63:0] dout;
  logic        dready, ddone, dv, dc, dn, dz;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  crp16_alu_seq #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .start(start16), .x(bx[15:0]), .y(by[15:0]),
    .select(bsel), .ready(ready16), .done(done16), .alu_out(out16),
    .v(v16), .c(c16), .n(n16), .z(z16)
  );

  crp16_alu_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .x(bx[7:0]), .y(by[7:0]),
    .select(bsel), .ready(ready8), .done(done8), .alu_out(out8),
    .v(v8), .c(c8), .n(n8), .z(z8)
  );

  always_comb begin
    if (cur_w == 8) begin
      dout = {56'd0, out8};
      {dready, ddone, dv, dc, dn, dz} = {ready8, done8, v8, c8, n8, z8};
    end else begin
      dout = {48'd0, out16};
      {dready, ddone, dv, dc, dn, dz} = {ready16, done16, v16, c16, n16, z16};
    end
  end

  // Reference: result, carry, overflow and latency in edges from acceptance to done.
  function automatic void model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                input logic [3:0] sel, output logic [63:0] r,
                                output logic rv, output logic rc, output int lat);
    logic [63:0] mask, a, b, full;
    longint sa, sb, sr, smax, smin;
    int s;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    sa = longint'(a);
    sb = longint'(b);
    if (a[w-1]) sa = sa - (longint'(1) << w);
    if (b[w-1]) sb = sb - (longint'(1) << w);
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    s = int'(b % 64'(w));
    rv = 1'b0;
    rc = 1'b0;
    lat = 1;
    r = '0;
    if (!sel[3]) begin
      if (!sel[0]) begin
        full = a + b;
        rc = full[w];
        sr = sa + sb;
      end else begin
        full = a - b;
        rc = (a >= b);
        sr = sa - sb;
      end
      r = full & mask;
      rv = (sr > smax) || (sr < smin);
    end else if (!sel[2]) begin
      case (sel[1:0])
        2'b00:   r = a & b;
        2'b01:   r = a | b;
        2'b10:   r = a ^ b;
        default: r = ~a & mask;
      endcase
    end else begin
      case (sel[1:0])
        2'b00: begin
          r = (a << s) & mask;
          if (s > 0) rc = a[w-s];
        end
        2'b01: begin
          r = a >> s;
          if (s > 0) rc = a[s-1];
        end
        2'b10: begin
          r = 64'(sa >>> s) & mask;
          if (s > 0) rc = a[s-1];
        end
        default: r = (sa < sb) ? 64'd1 : 64'd0;
      endcase
      if (sel[1:0] != 2'b11 && s > 0) lat = s + 1;
    end
  endfunction

  // Issue one op and follow it cycle by cycle until one cycle after done.
  task automatic do_op(input int w, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] sel, input bit inject, input string name);
    logic [63:0] er, prev, mask;
    logic ev, ec;
    int lat;
    model(w, a, b, sel, er, ev, ec, lat);
    mask = (64'd1 << w) - 64'd1;
    cur_w = w;
    #0;
    prev = dout;
    bx = a;
    by = b;
    bsel = sel;
    if (w == 8) start8 = 1'b1;
    else start16 = 1'b1;
    @(posedge clock);
    #1;
    start8 = 1'b0;
    start16 = 1'b0;
    bx = {$urandom, $urandom};
    by = {$urandom, $urandom};
    bsel = 4'($urandom);
    for (int cyc = 1; cyc <= lat + 1; cyc++) begin
      n_tests++;
      if (dready !== (cyc >= lat) || ddone !== (cyc == lat)) begin
        n_fail++;
        $display("FAIL %s handshake cyc %0d: ready=%b done=%b, need ready=%b done=%b",
                 name, cyc, dready, ddone, cyc >= lat, cyc == lat);
      end
      if (cyc < lat) begin
        n_tests++;
        if (dout !== prev) begin
          n_fail++;
          $display("FAIL %s hold cyc %0d: alu_out=%h need %h", name, cyc, dout, prev);
        end
      end
      if (cyc == lat) begin
        n_tests++;
        if (dout !== er || dv !== ev || dc !== ec || dn !== er[w-1] || dz !== (er == 0)) begin
          n_fail++;
          $display("FAIL %s result: out=%h vcnz=%b%b%b%b, need out=%h vcnz=%b%b%b%b",
                   name, dout, dv, dc, dn, dz, er, ev, ec, er[w-1], er == 0);
        end
      end
      if (inject && cyc == 2 && lat > 3) begin
        bx = 64'd1;
        by = 64'd1;
        bsel = 4'b0000;
        if (w == 8) start8 = 1'b1;
        else start16 = 1'b1;
      end else begin
        start8 = 1'b0;
        start16 = 1'b0;
      end
      if (cyc <= lat) begin
        @(posedge clock);
        #1;
      end
    end
    if (mask == 0) $display("unreachable");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cur_w = 16;
    #0;
    n_tests++;
    if (dready !== 1'b1 || ddone !== 1'b0 || dout !== 64'd0 || {dv, dc, dn, dz} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset16: ready=%b done=%b out=%h vcnz=%b%b%b%b, need 1 0 0 0000",
               dready, ddone, dout, dv, dc, dn, dz);
    end
    n_tests++;
    if (ready8 !== 1'b1 || done8 !== 1'b0 || out8 !== 8'd0 || {v8, c8, n8, z8} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset8: ready=%b done=%b out=%h, need 1 0 00", ready8, done8, out8);
    end
  endtask

  task automatic test_directed16();
    do_op(16, 64'h7FFF, 64'h0001, 4'b0000, 1'b0, "add_ovf");
    do_op(16, 64'h0005, 64'h0005, 4'b0001, 1'b0, "sub_zero");
    do_op(16, 64'h0000, 64'h0001, 4'b0001, 1'b0, "sub_borrow");
    do_op(16, 64'h8000, 64'h0003, 4'b1110, 1'b0, "sra3");
    do_op(16, 64'h1234, 64'h0010, 4'b1100, 1'b0, "sll_s0");
    do_op(16, 64'h0001, 64'h000F, 4'b1100, 1'b1, "sll15_inject");
    do_op(16, 64'hFFFF, 64'h0001, 4'b1111, 1'b0, "slt_true");
    do_op(16, 64'h0001, 64'hFFFF, 4'b1111, 1'b0, "slt_false");
    do_op(16, 64'hA5A5, 64'h0FF0, 4'b1000, 1'b0, "and");
    do_op(16, 64'hA5A5, 64'h0FF0, 4'b1001, 1'b0, "or");
    do_op(16, 64'hA5A5, 64'h0FF0, 4'b1010, 1'b0, "xor");
    do_op(16, 64'hA5A5, 64'h0FF0, 4'b1011, 1'b0, "not");
    do_op(16, 64'h8001, 64'h0001, 4'b1101, 1'b0, "srl1");
  endtask

  task automatic test_random16();
    for (int i = 0; i < 60; i++) begin
      do_op(16, 64'($urandom), 64'($urandom), 4'($urandom), (i % 5) == 0, "rand16");
    end
  endtask

  task automatic test_width8();
    do_op(8, 64'h7F, 64'h01, 4'b0000, 1'b0, "w8_add_ovf");
    do_op(8, 64'h80, 64'h03, 4'b1110, 1'b0, "w8_sra3");
    do_op(8, 64'h01, 64'h07, 4'b1100, 1'b1, "w8_sll7");
    for (int i = 0; i < 30; i++) begin
      do_op(8, 64'($urandom), 64'($urandom), 4'($urandom), (i % 4) == 0, "rand8");
    end
  endtask

  // Starts issued in the very cycle done is high must be accepted.
  task automatic test_back_to_back();
    logic [63:0] r1, r2, r3;
    logic v1, c1, v2, c2, v3, c3;
    int l1, l2, l3;
    model(16, 64'h1111, 64'h2222, 4'b0000, r1, v1, c1, l1);
    model(16, 64'h0003, 64'h0007, 4'b0001, r2, v2, c2, l2);
    model(16, 64'h00F1, 64'h0002, 4'b1100, r3, v3, c3, l3);
    cur_w = 16;
    bx = 64'h1111; by = 64'h2222; bsel = 4'b0000; start16 = 1'b1;
    @(posedge clock); #1;
    n_tests++;
    if (ddone !== 1'b1 || dready !== 1'b1 || dout !== r1) begin
      n_fail++;
      $display("FAIL b2b_op1: done=%b ready=%b out=%h, need 1 1 %h", ddone, dready, dout, r1);
    end
    bx = 64'h0003; by = 64'h0007; bsel = 4'b0001;
    @(posedge clock); #1;
    n_tests++;
    if (ddone !== 1'b1 || dout !== r2 || dc !== c2 || dn !== r2[15]) begin
      n_fail++;
      $display("FAIL b2b_op2: done=%b out=%h c=%b, need 1 %h %b", ddone, dout, dc, r2, c2);
    end
    bx = 64'h00F1; by = 64'h0002; bsel = 4'b1100;
    @(posedge clock); #1;
    start16 = 1'b0;
    n_tests++;
    if (ddone !== 1'b0 || dready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_op3_accept: done=%b ready=%b, need 0 0", ddone, dready);
    end
    @(posedge clock); #1;
    @(posedge clock); #1;
    n_tests++;
    if (ddone !== 1'b1 || dout !== r3 || dc !== c3 || l3 != 3) begin
      n_fail++;
      $display("FAIL b2b_op3: done=%b out=%h c=%b, need 1 %h %b", ddone, dout, dc, r3, c3);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_shift();
    int seen = 0;
    cur_w = 16;
    bx = 64'hFFFF; by = 64'd10; bsel = 4'b1101; start16 = 1'b1;
    @(posedge clock); #1;
    start16 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_tests++;
    if (dready !== 1'b1 || ddone !== 1'b0 || dout !== 64'd0 || {dv, dc, dn, dz} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid: ready=%b done=%b out=%h vcnz=%b%b%b%b, need 1 0 0 0000",
               dready, ddone, dout, dv, dc, dn, dz);
    end
    for (int i = 0; i < 12; i++) begin
      if (ddone === 1'b1) seen++;
      @(posedge clock); #1;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: done pulses=%0d need 0", seen);
    end
    do_op(16, 64'd2, 64'd3, 4'b0000, 1'b0, "add_after_reset");
  endtask

  initial begin
    test_reset();
    test_directed16();
    test_back_to_back();
    test_random16();
    test_width8();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
